bank_input_debouncer: RTL

- Input-side counterpart of the LED bank driver: samples 8 asynchronous input pins (buttons/switches) on one bank and produces clean, debounced levels.
- Also produces one-cycle rise/fall event pulses and a saturating press counter for consumers in the fabric.
- Timing is derived from a free-running prescaler, analogous to the LED counter, so debounce time is set by parameters rather than a PLL.

---
 rtl/bank_input_debouncer_pkg.sv | 22 ++
 rtl/bank_input_debouncer_debounce_bit.sv | 72 +++++++
 rtl/bank_input_debouncer.sv | 76 +++++++
 3 files changed

// File: rtl/bank_input_debouncer_pkg.sv
// Shared constants and helpers for the bank input debouncer.
// The sizing function is evaluated at elaboration time only.
package bank_input_debouncer_pkg;

    localparam int DEBOUNCE_TICK_DIV       = 65536;
    localparam int DEBOUNCE_STABLE_SAMPLES = 4;

    // Bits needed to hold 0..value-1; never less than 1 so a counter always exists.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < 32'(value)) begin
                result = i + 32'sd1;
            end else begin
                result = result;
            end
        end
        return (result < 32'sd1) ? 32'sd1 : result;
    endfunction

endpackage

// File: rtl/bank_input_debouncer_debounce_bit.sv
// One debounced input: two-flop synchronizer, stability counter, accepted level
// and registered one-cycle rise/fall pulses.
module debounce_bit
    import bank_input_debouncer_pkg::*;
#(
    parameter int STABLE_SAMPLES = DEBOUNCE_STABLE_SAMPLES
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W    = clog2(STABLE_SAMPLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Acceptance rule: a differing sample must persist for STABLE_SAMPLES ticks.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (tick) begin
            if (sync2_q == level_q) begin
                cnt_d = {CNT_W{1'b0}};
            end else if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = {CNT_W{1'b0}};
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Synchronizer flops feed each other directly; state registers follow.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pin;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/bank_input_debouncer.sv
// Debounces a bank of input pins on a shared prescaler tick and counts
// presses (rising edges) on bit 0 with a saturating, clearable counter.
module bank_input_debouncer
    import bank_input_debouncer_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int TICK_DIV       = DEBOUNCE_TICK_DIV,
    parameter int STABLE_SAMPLES = DEBOUNCE_STABLE_SAMPLES,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bank_in,
    input  logic             clr_count,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [CNT_W-1:0] press_count
);

    localparam int                 PRESC_W    = clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   COUNT_MAX  = {CNT_W{1'b1}};

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   press_q, press_d;
    logic               tick_s;

    assign tick_s = (presc_q == PRESC_LAST);

    // Next-state for the prescaler and the saturating press counter; clear beats increment.
    always_comb begin
        presc_d = presc_q;
        press_d = press_q;
        if (tick_s) begin
            presc_d = {PRESC_W{1'b0}};
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
        if (clr_count) begin
            press_d = {CNT_W{1'b0}};
        end else if (rise[0] && (press_q != COUNT_MAX)) begin
            press_d = press_q + CNT_W'(1);
        end else begin
            press_d = press_q;
        end
    end

    // Shared timing and counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= {PRESC_W{1'b0}};
            press_q <= {CNT_W{1'b0}};
        end else begin
            presc_q <= presc_d;
            press_q <= press_d;
        end
    end

    assign press_count = press_q;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .tick (tick_s),
            .pin  (bank_in[g]),
            .level(level[g]),
            .rise (rise[g]),
            .fall (fall[g])
        );
    end

endmodule
